cla_pipe_addsub: RTL and testbench
==================================

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and at least 4.
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port in_valid  input  1  an operation is offered on a, b, mode.
REQ-005 Port in_ready  output  1  block accepts the offered operation this cycle.
REQ-006 Port a  input  WIDTH  operand A.
REQ-007 Port b  input  WIDTH  operand B (ignored for ACC and CLR).
REQ-008 Port mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
REQ-009 Port out_valid  output  1  result fields are valid.
REQ-010 Port out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port sum  output  WIDTH  result.
REQ-012 Port cout  output  1  carry out of the MSB; for SUB, 1 means no borrow.
REQ-013 Port ovf  output  1  signed two's-complement overflow.

Function
REQ-014 Transfer in SHALL occur on an edge where in_valid && in_ready; transfer out SHALL occur on an edge where out_valid && out_ready.
REQ-015 Pipeline SHALL have two register stages: S1 (operand/mode capture, B inversion for SUB) and S2 (lookahead sum, result/flag registers).
REQ-016 Latency SHALL be 2: an operation accepted at edge k SHALL have out_valid high after edge k+1 when no stall occurs.
REQ-017 Throughput SHALL be one operation per cycle while out_ready stays high.
REQ-018 S2 SHALL load when S1 is valid and (!out_valid || out_ready); on a transfer out with S1 empty, out_valid SHALL fall.
REQ-019 in_ready SHALL equal !s1_valid || S2-loads-this-cycle; it SHALL NOT depend combinationally on in_valid.
REQ-020 While out_valid && !out_ready, sum, cout, ovf and out_valid SHALL hold, and S1 SHALL hold its contents.
REQ-021 ADD SHALL compute a+b with carry-in 0; SUB SHALL compute a+~b with carry-in 1.
REQ-022 ACC SHALL compute acc+a with carry-in 0, drive the result on sum, and write it to internal register acc (WIDTH bits) when S2 loads.
REQ-023 CLR SHALL set acc to 0 when S2 loads and SHALL output sum=0, cout=0, ovf=0.
REQ-024 acc SHALL change only on S2 loads of ACC or CLR ops, so back-to-back ACC ops chain without hazard.
REQ-025 ovf SHALL be set when both effective operands have equal MSBs and the sum MSB differs; it SHALL be 0 for CLR.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
REQ-027 Carries SHALL be formed by 4-bit groups with group generate/propagate and lookahead across groups; no ripple chain across groups.

Reset
REQ-028 While rst is high at an edge: s1_valid, out_valid, sum, cout, ovf and acc SHALL all clear to 0.
REQ-029 rst asserted mid-operation SHALL discard all in-flight operations without emitting them; in_ready SHALL be 1 in the cycle after reset deasserts.

Structure
REQ-030 Shared package cla_pkg SHALL hold the mode encodings (MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR) and the group size constant GRP=4.
REQ-031 One sub-module, cla_group4, SHALL take 4-bit p/g plus carry-in, produce the 4 sum bits and group G/P, and be instantiated WIDTH/4 times.

Verification (WIDTH=16)
REQ-032 ADD a=16'hFFFF, b=16'h0001 -> sum 16'h0000, cout 1, ovf 0, out_valid two edges after acceptance.
REQ-033 SUB a=16'h8000, b=16'h0001 -> sum 16'h7FFF, cout 1, ovf 1; SUB a=5, b=7 -> sum 16'hFFFE, cout 0.
REQ-034 CLR, then ACC 3, ACC 4, ACC 16'h7FFF issued back-to-back -> sums 3, 7, 16'h8006 with ovf 1 on the last result.
REQ-035 Stream 8 ADDs with out_ready held low for 3 cycles mid-stream -> outputs hold steady, in_ready drops, and no op is lost, duplicated or reordered.
REQ-036 Pulse rst with two ops in flight and acc=9 -> no out_valid pulse for those ops, acc reads 0 (next ACC 1 -> sum 1).

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/sub/accumulate unit:
// operation encodings, lookahead group size and the overflow rule.
package cla_pkg;

  localparam int GRP = 4;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                      input logic sum_msb);
    return (x_msb == y_msb) && (sum_msb != x_msb);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead slice: internal carries from bit p/g and the group
// carry-in, plus group generate/propagate for the next lookahead level.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP-1:0] p,
  input  logic [GRP-1:0] g,
  input  logic           cin,
  output logic [GRP-1:0] s,
  output logic           grp_gen,
  output logic           grp_prop
);

  logic [GRP-1:0] c;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign grp_gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
  assign grp_prop = &p;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined add/sub/accumulate unit with valid/ready handshakes on
// both sides and a two-level carry-lookahead adder between S1 and S2.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / GRP;
  localparam int MSB  = WIDTH - 1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  mode_e            s1_mode;
  logic             s1_cin;

  logic [WIDTH-1:0] acc;

  logic             in_fire;
  logic             s2_load;

  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] bit_p;
  logic [WIDTH-1:0] bit_g;
  logic [WIDTH-1:0] raw_sum;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  // SUB is folded into an add here so S2 only ever sees x + y + cin.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_ADD;
      s1_cin   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= (mode_e'(mode) == MODE_SUB) ? ~b : b;
      s1_mode  <= mode_e'(mode);
      s1_cin   <= (mode_e'(mode) == MODE_SUB);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // acc is read here, in S2, so an ACC right behind another sees its result.
  always_comb begin
    op_x = s1_a;
    op_y = s1_b;
    if (s1_mode == MODE_ACC) begin
      op_x = acc;
      op_y = s1_a;
    end
  end

  assign bit_p = op_x ^ op_y;
  assign bit_g = op_x & op_y;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    cla_group4 u_grp (
      .p        (bit_p[gi*GRP +: GRP]),
      .g        (bit_g[gi*GRP +: GRP]),
      .cin      (grp_c[gi]),
      .s        (raw_sum[gi*GRP +: GRP]),
      .grp_gen  (grp_g[gi]),
      .grp_prop (grp_p[gi])
    );
  end

  // Each group carry is a flat sum of products over lower-group G/P terms,
  // so no group waits on the carry produced by the group beneath it.
  always_comb begin
    logic term;
    term  = 1'b0;
    grp_c = '0;
    for (int j = 0; j <= NGRP; j++) begin
      term = s1_cin;
      for (int m = 0; m < j; m++) term = term & grp_p[m];
      grp_c[j] = term;
      for (int k = 0; k < j; k++) begin
        term = grp_g[k];
        for (int m = k + 1; m < j; m++) term = term & grp_p[m];
        grp_c[j] = grp_c[j] | term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      if (s1_mode == MODE_CLR) begin
        sum  <= '0;
        cout <= 1'b0;
        ovf  <= 1'b0;
        acc  <= '0;
      end else begin
        sum  <= raw_sum;
        cout <= grp_c[NGRP];
        ovf  <= signed_ovf(op_x[MSB], op_y[MSB], raw_sum[MSB]);
        if (s1_mode == MODE_ACC) acc <= raw_sum;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub (WIDTH=16): a table of single operations
// with hand-computed results, then back-to-back, stall and reset sequences.
module tb_cla_pipe_addsub;
  import cla_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } out_rec_t;

  vec_t     vecs[14];
  out_rec_t got_q[$];

  logic [W-1:0] snap_sum;
  logic         snap_cout;

  cla_pipe_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Inputs change just after rising edges, so at the falling edge the
  // handshake is settled and out_valid && out_ready means a transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back('{sum: sum, cout: cout, ovf: ovf, cyc: cyc});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] md, input logic [W-1:0] av,
                               input logic [W-1:0] bv);
    logic ready;
    logic done;
    done     = 1'b0;
    mode     = md;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      ready = in_ready;
      @(posedge clk);
      #1;
      done = ready;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int budget;
    budget = 50;
    while (got_q.size() < n && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checkOutput("output_count", got_q.size(), n);
  endtask

  task automatic check_rec(input string name, input int idx,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    if (got_q.size() > idx) begin
      checkOutput({name, "_sum"},  got_q[idx].sum,  es);
      checkOutput({name, "_cout"}, got_q[idx].cout, ec);
      checkOutput({name, "_ovf"},  got_q[idx].ovf,  eo);
    end else begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_missing actual=absent required=present", name);
    end
  endtask

  initial begin
    vecs[0]  = '{MODE_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{MODE_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[2]  = '{MODE_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{MODE_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{MODE_ADD, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[5]  = '{MODE_SUB, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{MODE_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{MODE_SUB, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
    vecs[8]  = '{MODE_ADD, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0};
    vecs[9]  = '{MODE_ADD, 16'h00FF, 16'hFF01, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{MODE_CLR, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{MODE_ACC, 16'h0003, 16'hAAAA, 16'h0003, 1'b0, 1'b0};
    vecs[12] = '{MODE_ACC, 16'hFFFF, 16'h5555, 16'h0002, 1'b1, 1'b0};
    vecs[13] = '{MODE_CLR, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = 2'b00;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    checkOutput("reset_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // One operation at a time: invisible one edge after acceptance, valid after two.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_early_valid", i), out_valid, 0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_out_valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
      checkOutput($sformatf("vec%0d_cout", i), cout, vecs[i].exp_cout);
      checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
      @(posedge clk);
      #1;
    end

    // Back-to-back accumulate chain.
    got_q.delete();
    applyStimulus(MODE_CLR, 16'h0000, 16'h0000);
    applyStimulus(MODE_ACC, 16'h0003, 16'h0000);
    applyStimulus(MODE_ACC, 16'h0004, 16'h0000);
    applyStimulus(MODE_ACC, 16'h7FFF, 16'h0000);
    wait_outputs(4);
    check_rec("chain_clr", 0, 16'h0000, 1'b0, 1'b0);
    check_rec("chain_acc3", 1, 16'h0003, 1'b0, 1'b0);
    check_rec("chain_acc4", 2, 16'h0007, 1'b0, 1'b0);
    check_rec("chain_acc7fff", 3, 16'h8006, 1'b0, 1'b1);
    if (got_q.size() >= 4)
      checkOutput("chain_back_to_back_cycles", got_q[3].cyc - got_q[0].cyc, 3);

    // Eight-op stream with a three-cycle consumer stall in the middle.
    @(posedge clk);
    #1;
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(MODE_ADD, 16'(i * 16'h1111), 16'h0001);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap_sum  = sum;
        snap_cout = cout;
        checkOutput("stall_out_valid", out_valid, 1);
        checkOutput("stall_in_ready", in_ready, 0);
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          checkOutput($sformatf("stall%0d_hold_sum", s), sum, snap_sum);
          checkOutput($sformatf("stall%0d_hold_cout", s), cout, snap_cout);
          checkOutput($sformatf("stall%0d_hold_valid", s), out_valid, 1);
          checkOutput($sformatf("stall%0d_in_ready", s), in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_outputs(8);
    for (int i = 0; i < 8; i++)
      check_rec($sformatf("stream%0d", i), i, 16'(i * 16'h1111 + 1), 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stream_no_duplicates", got_q.size(), 8);

    // Reset with two ops in flight while acc holds 9.
    got_q.delete();
    applyStimulus(MODE_CLR, 16'h0000, 16'h0000);
    applyStimulus(MODE_ACC, 16'h0009, 16'h0000);
    wait_outputs(2);
    check_rec("preload_acc9", 1, 16'h0009, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    got_q.delete();
    out_ready = 1'b0;
    applyStimulus(MODE_ADD, 16'h0001, 16'h0001);
    applyStimulus(MODE_ADD, 16'h0002, 16'h0002);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_sum", sum, 0);
    checkOutput("flush_in_ready", in_ready, 1);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checkOutput($sformatf("flush_no_pulse%0d", t), out_valid, 0);
    end
    checkOutput("flush_nothing_emitted", got_q.size(), 0);
    @(posedge clk);
    #1;
    applyStimulus(MODE_ACC, 16'h0001, 16'h0000);
    wait_outputs(1);
    check_rec("after_reset_acc1", 0, 16'h0001, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
